// File: rtl/wsn_channel_pkg.sv
// Shared constants and helpers for the WSN radio channel emulator.
//   - LFSR width, Galois tap mask (x^16+x^14+x^13+x^11+1) and default seed
//   - default delay-line depth / pointer width and statistics counter width
//   - eff_seed(): maps a zero seed to the default so the LFSR never locks up
//   - lfsr_step(): one right-shifting Galois step
package wsn_channel_pkg;

  localparam int                 LFSR_W            = 16;
  localparam logic [LFSR_W-1:0]  LFSR_TAPS         = 16'hB400;
  localparam logic [LFSR_W-1:0]  DEFAULT_SEED      = 16'hACE1;
  localparam int                 DEFAULT_MAX_DELAY = 64;
  localparam int                 DEFAULT_DW        = 6;
  localparam int                 DEFAULT_CNT_W     = 32;

  function automatic logic [LFSR_W-1:0] eff_seed(input logic [LFSR_W-1:0] s);
    return (s == '0) ? DEFAULT_SEED : s;
  endfunction

  // Shift right; when the bit leaving at the bottom is 1, fold the taps back in.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/wsn_lfsr16.sv
// 16-bit Galois LFSR used as the bit-error random source.
// Ports:
//   clk   in   system clock
//   reset in   synchronous active-high reset, loads seed (zero seed -> default)
//   en    in   advance one step this cycle
//   seed  in   reset value
//   state out  current LFSR value (never 0)
module wsn_lfsr16
  import wsn_channel_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= eff_seed(seed);
    end else if (en) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/wsn_channel_emu.sv
// Single-direction radio channel emulator: programmable propagation delay,
// pseudo-random bit errors and a link-down gate, with pass/flip counters.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   antena_in    transmitted bit, sampled every cycle
//   antena_out   received bit, registered (delay+1 cycles after antena_in)
//   enable       1 = link up, 0 = link down (output forced to 0)
//   delay        extra latency in cycles, 0..MAX_DELAY-1
//   ber_thresh   flip when LFSR < ber_thresh; 0 disables errors
//   clr_stats    one-cycle pulse clearing both counters (wins over increment)
//   bit_cnt      saturating count of enabled cycles
//   flip_cnt     saturating count of injected bit flips
module wsn_channel_emu
  import wsn_channel_pkg::*;
#(
  parameter int                MAX_DELAY = DEFAULT_MAX_DELAY,
  parameter int                DW        = DEFAULT_DW,
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED,
  parameter int                CNT_W     = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              antena_in,
  output logic              antena_out,
  input  logic              enable,
  input  logic [DW-1:0]     delay,
  input  logic [15:0]       ber_thresh,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic [CNT_W-1:0]  flip_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [MAX_DELAY-1:0] r_buf;
  logic [DW-1:0]        r_wptr;
  logic                 r_out;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [CNT_W-1:0]     r_flip_cnt;

  logic [DW-1:0]        w_rptr;
  logic                 w_delayed;
  logic                 w_flip;
  logic [LFSR_W-1:0]    w_lfsr;

  wsn_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (enable),
    .seed  (SEED),
    .state (w_lfsr)
  );

  // Circular delay line. The slot at wptr still holds the bit from MAX_DELAY
  // cycles ago, so delay=0 must bypass straight from antena_in; any other
  // delay reads a slot written 'delay' cycles earlier. Modular DW-bit
  // subtraction handles wrap-around, and delay=MAX_DELAY-1 lands on wptr+1,
  // which never aliases the slot being written this cycle.
  assign w_rptr    = r_wptr - delay;
  assign w_delayed = (delay == '0) ? antena_in : r_buf[w_rptr];

  // Compare against the LFSR value before this cycle's advance.
  assign w_flip = enable & (ber_thresh != 16'h0000) & (w_lfsr < ber_thresh);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf  <= '0;
      r_wptr <= '0;
      r_out  <= 1'b0;
    end else begin
      r_buf[r_wptr] <= antena_in;
      r_wptr        <= r_wptr + DW'(1);
      r_out         <= enable ? (w_delayed ^ w_flip) : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      r_bit_cnt  <= '0;
      r_flip_cnt <= '0;
    end else begin
      if (enable && (r_bit_cnt != CNT_MAX)) begin
        r_bit_cnt <= r_bit_cnt + CNT_ONE;
      end
      if (w_flip && (r_flip_cnt != CNT_MAX)) begin
        r_flip_cnt <= r_flip_cnt + CNT_ONE;
      end
    end
  end

  assign antena_out = r_out;
  assign bit_cnt    = r_bit_cnt;
  assign flip_cnt   = r_flip_cnt;

endmodule
